// File: rtl/cprv_mem_stage.sv
// Memory-access stage of the cprv64g pipeline: one dmem access per LOAD/STORE, result handed to writeback.
// Optional misaligned-access trap is enabled with the CPRV_MISALIGN_TRAP_EN macro.
module cprv_mem_stage #(
    parameter int DATA_WIDTH = 64,
    parameter int IMM_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_mem_i,
    output logic                  ready_mem_o,
    input  logic [DATA_WIDTH-1:0] rs2_data_mem_i,
    input  logic [4:0]            rd_addr_mem_i,
    input  logic                  rd_en_mem_i,
    input  logic [IMM_WIDTH-1:0]  imm_data_mem_i,
    input  logic [6:0]            opcode_mem_i,
    input  logic [2:0]            funct3_mem_i,
    input  logic [DATA_WIDTH-1:0] alu_out_mem_i,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    output logic [DATA_WIDTH-1:0] dmem_addr_o,
    output logic [DATA_WIDTH-1:0] dmem_wdata_o,
    output logic [7:0]            dmem_wstrb_o,
    input  logic                  dmem_ack_i,
    input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
`ifdef CPRV_MISALIGN_TRAP_EN
    output logic                  misalign_wb_o,
`endif
    output logic                  valid_wb_o,
    input  logic                  ready_wb_i,
    output logic [4:0]            rd_addr_wb_o,
    output logic                  rd_en_wb_o,
    output logic [IMM_WIDTH-1:0]  imm_data_wb_o,
    output logic [6:0]            opcode_wb_o,
    output logic [2:0]            funct3_wb_o,
    output logic [DATA_WIDTH-1:0] alu_out_wb_o,
    output logic [DATA_WIDTH-1:0] mem_data_wb_o
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {IDLE, MEM, SEND} state_t;
    state_t state;

    function automatic logic [2:0] align_off(input logic [1:0] size, input logic [2:0] off);
        case (size)
            2'd0:    align_off = off;
            2'd1:    align_off = {off[2:1], 1'b0};
            2'd2:    align_off = {off[2], 2'b00};
            default: align_off = 3'd0;
        endcase
    endfunction

    function automatic logic [7:0] store_strb(input logic [1:0] size, input logic [2:0] off);
        case (size)
            2'd0:    store_strb = 8'h01 << off;
            2'd1:    store_strb = 8'h03 << off;
            2'd2:    store_strb = 8'h0F << off;
            default: store_strb = 8'hFF;
        endcase
    endfunction

    function automatic logic [63:0] store_data(input logic [1:0] size, input logic [63:0] rs2);
        case (size)
            2'd0:    store_data = {8{rs2[7:0]}};
            2'd1:    store_data = {4{rs2[15:0]}};
            2'd2:    store_data = {2{rs2[31:0]}};
            default: store_data = rs2;
        endcase
    endfunction

    function automatic logic [63:0] load_ext(input logic [63:0] rdata, input logic [2:0] f3,
                                             input logic [2:0] off);
        logic [63:0]        sh;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] w;
        sh = rdata >> {off, 3'b000};
        b  = sh[7:0];
        h  = sh[15:0];
        w  = sh[31:0];
        case (f3[1:0])
            2'd0:    load_ext = f3[2] ? {56'd0, sh[7:0]}  : 64'(b);
            2'd1:    load_ext = f3[2] ? {48'd0, sh[15:0]} : 64'(h);
            2'd2:    load_ext = f3[2] ? {32'd0, sh[31:0]} : 64'(w);
            default: load_ext = sh;
        endcase
    endfunction

    logic       vld_p0;
    logic       is_load_p0;
    logic       is_store_p0;
    logic [1:0] size_p0;
    logic [2:0] off_p0;
    logic       trap_p0;

    assign ready_mem_o = (state == IDLE) || ((state == SEND) && ready_wb_i);
    assign vld_p0      = valid_mem_i && ready_mem_o;
    assign is_load_p0  = (opcode_mem_i == OP_LOAD);
    assign is_store_p0 = (opcode_mem_i == OP_STORE);
    assign size_p0     = funct3_mem_i[1:0];
    assign off_p0      = align_off(size_p0, alu_out_mem_i[2:0]);

`ifdef CPRV_MISALIGN_TRAP_EN
    assign trap_p0 = (is_load_p0 || is_store_p0) && (off_p0 != alu_out_mem_i[2:0]);
`else
    assign trap_p0 = 1'b0;
`endif

    // capture from execute (p0) -> memory access / writeback registers (p1)
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            valid_wb_o    <= 1'b0;
            dmem_req_o    <= 1'b0;
            dmem_we_o     <= 1'b0;
            dmem_addr_o   <= '0;
            dmem_wdata_o  <= '0;
            dmem_wstrb_o  <= 8'd0;
            rd_addr_wb_o  <= 5'd0;
            rd_en_wb_o    <= 1'b0;
            imm_data_wb_o <= '0;
            opcode_wb_o   <= 7'd0;
            funct3_wb_o   <= 3'd0;
            alu_out_wb_o  <= '0;
            mem_data_wb_o <= '0;
`ifdef CPRV_MISALIGN_TRAP_EN
            misalign_wb_o <= 1'b0;
`endif
        end else if (vld_p0) begin
            rd_addr_wb_o  <= rd_addr_mem_i;
            rd_en_wb_o    <= rd_en_mem_i && !is_store_p0 && !trap_p0;
            imm_data_wb_o <= imm_data_mem_i;
            opcode_wb_o   <= opcode_mem_i;
            funct3_wb_o   <= funct3_mem_i;
            alu_out_wb_o  <= alu_out_mem_i;
            mem_data_wb_o <= '0;
            dmem_addr_o   <= {alu_out_mem_i[63:3], 3'b000};
            dmem_wdata_o  <= store_data(size_p0, rs2_data_mem_i);
`ifdef CPRV_MISALIGN_TRAP_EN
            misalign_wb_o <= trap_p0;
`endif
            if ((is_load_p0 || is_store_p0) && !trap_p0) begin
                state        <= MEM;
                valid_wb_o   <= 1'b0;
                dmem_req_o   <= 1'b1;
                dmem_we_o    <= is_store_p0;
                dmem_wstrb_o <= is_store_p0 ? store_strb(size_p0, off_p0) : 8'd0;
            end else begin
                state        <= SEND;
                valid_wb_o   <= 1'b1;
                dmem_req_o   <= 1'b0;
                dmem_we_o    <= 1'b0;
                dmem_wstrb_o <= 8'd0;
            end
        end else begin
            case (state)
                MEM: begin
                    if (dmem_ack_i) begin
                        // extraction uses the captured funct3/offset, not the live execute inputs
                        if (opcode_wb_o == OP_LOAD)
                            mem_data_wb_o <= load_ext(dmem_rdata_i, funct3_wb_o,
                                                      align_off(funct3_wb_o[1:0], alu_out_wb_o[2:0]));
                        state        <= SEND;
                        valid_wb_o   <= 1'b1;
                        dmem_req_o   <= 1'b0;
                        dmem_we_o    <= 1'b0;
                        dmem_wstrb_o <= 8'd0;
                    end
                end
                SEND: begin
                    if (ready_wb_i) begin
                        state      <= IDLE;
                        valid_wb_o <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cprv_mem_stage.sv
// Directed bench for cprv_mem_stage: table of load/store/pass-through vectors plus handshake corner sequences.
module tb_cprv_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_mem_i;
    logic        ready_mem_o;
    logic [63:0] rs2_data_mem_i;
    logic [4:0]  rd_addr_mem_i;
    logic        rd_en_mem_i;
    logic [31:0] imm_data_mem_i;
    logic [6:0]  opcode_mem_i;
    logic [2:0]  funct3_mem_i;
    logic [63:0] alu_out_mem_i;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [63:0] dmem_addr_o;
    logic [63:0] dmem_wdata_o;
    logic [7:0]  dmem_wstrb_o;
    logic        dmem_ack_i;
    logic [63:0] dmem_rdata_i;
    logic        valid_wb_o;
    logic        ready_wb_i;
    logic [4:0]  rd_addr_wb_o;
    logic        rd_en_wb_o;
    logic [31:0] imm_data_wb_o;
    logic [6:0]  opcode_wb_o;
    logic [2:0]  funct3_wb_o;
    logic [63:0] alu_out_wb_o;
    logic [63:0] mem_data_wb_o;
`ifdef CPRV_MISALIGN_TRAP_EN
    logic        misalign_wb_o;
`endif

    always #5 clk = ~clk;

    cprv_mem_stage dut (
        .clk(clk), .rst(rst),
        .valid_mem_i(valid_mem_i), .ready_mem_o(ready_mem_o),
        .rs2_data_mem_i(rs2_data_mem_i), .rd_addr_mem_i(rd_addr_mem_i),
        .rd_en_mem_i(rd_en_mem_i), .imm_data_mem_i(imm_data_mem_i),
        .opcode_mem_i(opcode_mem_i), .funct3_mem_i(funct3_mem_i),
        .alu_out_mem_i(alu_out_mem_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_wstrb_o(dmem_wstrb_o),
        .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
`ifdef CPRV_MISALIGN_TRAP_EN
        .misalign_wb_o(misalign_wb_o),
`endif
        .valid_wb_o(valid_wb_o), .ready_wb_i(ready_wb_i),
        .rd_addr_wb_o(rd_addr_wb_o), .rd_en_wb_o(rd_en_wb_o),
        .imm_data_wb_o(imm_data_wb_o), .opcode_wb_o(opcode_wb_o),
        .funct3_wb_o(funct3_wb_o), .alu_out_wb_o(alu_out_wb_o),
        .mem_data_wb_o(mem_data_wb_o)
    );

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ADD   = 7'b0110011;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [63:0] alu;
        logic [63:0] rs2;
        logic [63:0] rdata;
        logic [63:0] exp_mem;
        logic [63:0] exp_addr;
        logic [7:0]  exp_strb;
        logic [63:0] exp_wdata;
        logic        exp_rd_en;
    } vec_t;

    vec_t vecs[14];
    int   n_vec;
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive_op(input logic [6:0] op, input logic [2:0] f3, input logic [63:0] alu,
                            input logic [63:0] rs2, input logic [4:0] rd);
        valid_mem_i    = 1'b1;
        opcode_mem_i   = op;
        funct3_mem_i   = f3;
        alu_out_mem_i  = alu;
        rs2_data_mem_i = rs2;
        rd_addr_mem_i  = rd;
        rd_en_mem_i    = 1'b1;
        imm_data_mem_i = {27'd0, rd} + 32'h100;
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        v = vecs[i];
        @(negedge clk);
        ready_wb_i = 1'b0;
        drive_op(v.op, v.f3, v.alu, v.rs2, 5'(i + 1));
        chk("ready_idle", 64'(ready_mem_o), 64'd1);
        @(negedge clk);
        valid_mem_i = 1'b0;
        if (v.op == OP_LOAD || v.op == OP_STORE) begin
            chk("req", 64'(dmem_req_o), 64'd1);
            chk("we", 64'(dmem_we_o), 64'(v.op == OP_STORE));
            chk("addr", dmem_addr_o, v.exp_addr);
            chk("wstrb", 64'(dmem_wstrb_o), 64'(v.exp_strb));
            if (v.op == OP_STORE) chk("wdata", dmem_wdata_o, v.exp_wdata);
            chk("valid_in_mem", 64'(valid_wb_o), 64'd0);
            @(negedge clk);
            chk("addr_hold", dmem_addr_o, v.exp_addr);
            chk("req_hold", 64'(dmem_req_o), 64'd1);
            dmem_ack_i   = 1'b1;
            dmem_rdata_i = v.rdata;
            @(negedge clk);
            dmem_ack_i   = 1'b0;
            dmem_rdata_i = 64'hDEAD_DEAD_DEAD_DEAD;
        end
        chk("valid_wb", 64'(valid_wb_o), 64'd1);
        chk("req_after", 64'(dmem_req_o), 64'd0);
        chk("mem_data", mem_data_wb_o, v.exp_mem);
        chk("rd_en", 64'(rd_en_wb_o), 64'(v.exp_rd_en));
        chk("rd_addr", 64'(rd_addr_wb_o), 64'(i + 1));
        chk("alu_out", alu_out_wb_o, v.alu);
        chk("imm", 64'(imm_data_wb_o), 64'(i + 1 + 32'h100));
        ready_wb_i = 1'b1;
        @(negedge clk);
        ready_wb_i = 1'b0;
        chk("valid_drop", 64'(valid_wb_o), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //            op        f3      alu          rs2                     rdata                   exp_mem                 exp_addr     strb   exp_wdata               rd_en
        vecs[0]  = '{OP_LOAD,  3'b000, 64'h1003, 64'h0,                 64'h00000000_80000000, 64'hFFFFFFFF_FFFFFF80, 64'h1000, 8'h00, 64'h0,                 1'b1};
        vecs[1]  = '{OP_LOAD,  3'b100, 64'h1003, 64'h0,                 64'h00000000_80000000, 64'h00000000_00000080, 64'h1000, 8'h00, 64'h0,                 1'b1};
        vecs[2]  = '{OP_LOAD,  3'b001, 64'h1006, 64'h0,                 64'h8001_0000_0000_0000, 64'hFFFFFFFF_FFFF8001, 64'h1000, 8'h00, 64'h0,               1'b1};
        vecs[3]  = '{OP_LOAD,  3'b101, 64'h1006, 64'h0,                 64'h8001_0000_0000_0000, 64'h00000000_00008001, 64'h1000, 8'h00, 64'h0,               1'b1};
        vecs[4]  = '{OP_LOAD,  3'b010, 64'h2004, 64'h0,                 64'hF0000001_00000000, 64'hFFFFFFFF_F0000001, 64'h2000, 8'h00, 64'h0,                 1'b1};
        vecs[5]  = '{OP_LOAD,  3'b110, 64'h2004, 64'h0,                 64'hF0000001_00000000, 64'h00000000_F0000001, 64'h2000, 8'h00, 64'h0,                 1'b1};
        vecs[6]  = '{OP_LOAD,  3'b011, 64'h2008, 64'h0,                 64'h01234567_89ABCDEF, 64'h01234567_89ABCDEF, 64'h2008, 8'h00, 64'h0,                 1'b1};
        vecs[7]  = '{OP_STORE, 3'b010, 64'h2004, 64'h12345678_DEADBEEF, 64'h0,                 64'h0,                 64'h2000, 8'hF0, 64'hDEADBEEF_DEADBEEF, 1'b0};
        vecs[8]  = '{OP_STORE, 3'b000, 64'h3005, 64'h00000000_000000AB, 64'h0,                 64'h0,                 64'h3000, 8'h20, 64'hABABABAB_ABABABAB, 1'b0};
        vecs[9]  = '{OP_STORE, 3'b001, 64'h3006, 64'h00000000_00001122, 64'h0,                 64'h0,                 64'h3000, 8'hC0, 64'h11221122_11221122, 1'b0};
        vecs[10] = '{OP_STORE, 3'b011, 64'h3010, 64'hCAFEBABE_00C0FFEE, 64'h0,                 64'h0,                 64'h3010, 8'hFF, 64'hCAFEBABE_00C0FFEE, 1'b0};
        vecs[11] = '{OP_ADD,   3'b000, 64'h55,   64'h0,                 64'h0,                 64'h0,                 64'h0,    8'h00, 64'h0,                 1'b1};
        // misaligned H/W accesses fall back to the naturally aligned offset
        vecs[12] = '{OP_LOAD,  3'b010, 64'h2007, 64'h0,                 64'hF0000001_00000000, 64'hFFFFFFFF_F0000001, 64'h2000, 8'h00, 64'h0,                 1'b1};
        vecs[13] = '{OP_STORE, 3'b001, 64'h3007, 64'h00000000_00001122, 64'h0,                 64'h0,                 64'h3000, 8'hC0, 64'h11221122_11221122, 1'b0};
`ifdef CPRV_MISALIGN_TRAP_EN
        n_vec = 12;
`else
        n_vec = 14;
`endif

        rst = 1'b1; valid_mem_i = 1'b0; ready_wb_i = 1'b0; dmem_ack_i = 1'b0;
        dmem_rdata_i = '0; rs2_data_mem_i = '0; rd_addr_mem_i = '0; rd_en_mem_i = 1'b0;
        imm_data_mem_i = '0; opcode_mem_i = '0; funct3_mem_i = '0; alu_out_mem_i = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_valid", 64'(valid_wb_o), 64'd0);
        chk("rst_req", 64'(dmem_req_o), 64'd0);
        chk("rst_we", 64'(dmem_we_o), 64'd0);
        chk("rst_wstrb", 64'(dmem_wstrb_o), 64'd0);
        chk("rst_ready", 64'(ready_mem_o), 64'd1);
        chk("rst_alu", alu_out_wb_o, 64'd0);
        chk("rst_mem", mem_data_wb_o, 64'd0);

        for (int i = 0; i < n_vec; i++) run_vec(i);

        // pass-through held by writeback back-pressure
        @(negedge clk);
        drive_op(OP_ADD, 3'b000, 64'h55, 64'h0, 5'd7);
        @(negedge clk);
        valid_mem_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("bp_valid", 64'(valid_wb_o), 64'd1);
            chk("bp_ready_mem", 64'(ready_mem_o), 64'd0);
            chk("bp_alu", alu_out_wb_o, 64'h55);
            chk("bp_rd", 64'(rd_addr_wb_o), 64'd7);
            @(negedge clk);
        end
        ready_wb_i = 1'b1;
        #1;
        chk("bp_ready_comb", 64'(ready_mem_o), 64'd1);
        @(negedge clk);
        ready_wb_i = 1'b0;
        chk("bp_released", 64'(valid_wb_o), 64'd0);

        // back-to-back pass-through with writeback always ready
        ready_wb_i = 1'b1;
        drive_op(OP_ADD, 3'b000, 64'h1, 64'h0, 5'd1);
        @(negedge clk);
        chk("b2b_v1", 64'(valid_wb_o), 64'd1);
        chk("b2b_alu1", alu_out_wb_o, 64'h1);
        chk("b2b_ready", 64'(ready_mem_o), 64'd1);
        drive_op(OP_ADD, 3'b000, 64'h2, 64'h0, 5'd2);
        @(negedge clk);
        valid_mem_i = 1'b0;
        chk("b2b_v2", 64'(valid_wb_o), 64'd1);
        chk("b2b_alu2", alu_out_wb_o, 64'h2);
        @(negedge clk);
        chk("b2b_end", 64'(valid_wb_o), 64'd0);
        ready_wb_i = 1'b0;

        // ack in the very first MEM cycle
        drive_op(OP_LOAD, 3'b011, 64'h4008, 64'h0, 5'd3);
        @(negedge clk);
        valid_mem_i  = 1'b0;
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = 64'h0BAD_F00D_1234_5678;
        @(negedge clk);
        dmem_ack_i = 1'b0;
        chk("fast_ack_valid", 64'(valid_wb_o), 64'd1);
        chk("fast_ack_data", mem_data_wb_o, 64'h0BAD_F00D_1234_5678);
        chk("fast_ack_req", 64'(dmem_req_o), 64'd0);
        ready_wb_i = 1'b1;
        @(negedge clk);
        ready_wb_i = 1'b0;

        // reset during MEM drops the access; a late ack is ignored
        drive_op(OP_LOAD, 3'b011, 64'h4000, 64'h0, 5'd4);
        @(negedge clk);
        valid_mem_i = 1'b0;
        chk("rm_req", 64'(dmem_req_o), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rm_req_drop", 64'(dmem_req_o), 64'd0);
        chk("rm_valid", 64'(valid_wb_o), 64'd0);
        chk("rm_ready", 64'(ready_mem_o), 64'd1);
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        dmem_ack_i = 1'b0;
        chk("late_ack_valid", 64'(valid_wb_o), 64'd0);
        chk("late_ack_mem", mem_data_wb_o, 64'd0);
        chk("late_ack_ready", 64'(ready_mem_o), 64'd1);

`ifdef CPRV_MISALIGN_TRAP_EN
        // misaligned word load traps without touching memory
        drive_op(OP_LOAD, 3'b010, 64'h3002, 64'h0, 5'd9);
        @(negedge clk);
        valid_mem_i = 1'b0;
        chk("mis_req", 64'(dmem_req_o), 64'd0);
        chk("mis_valid", 64'(valid_wb_o), 64'd1);
        chk("mis_flag", 64'(misalign_wb_o), 64'd1);
        chk("mis_rd_en", 64'(rd_en_wb_o), 64'd0);
        chk("mis_mem", mem_data_wb_o, 64'd0);
        ready_wb_i = 1'b1;
        @(negedge clk);
        ready_wb_i = 1'b0;
        drive_op(OP_LOAD, 3'b010, 64'h3004, 64'h0, 5'd9);
        @(negedge clk);
        valid_mem_i = 1'b0;
        chk("al_req", 64'(dmem_req_o), 64'd1);
        chk("al_flag", 64'(misalign_wb_o), 64'd0);
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = 64'h00000005_00000000;
        @(negedge clk);
        dmem_ack_i = 1'b0;
        chk("al_mem", mem_data_wb_o, 64'd5);
        ready_wb_i = 1'b1;
        @(negedge clk);
        ready_wb_i = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
